// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer and its
// load-use comparator.
package hazard_pkg;

    localparam int STATE_W = 2;
    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic [STATE_W-1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_stall;
    } pipe_ctrl_t;

    // One control bundle per pipe situation; the sequencer only selects between them.
    localparam pipe_ctrl_t CTRL_HALT   = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                           idex_bubble: 1'b1, pipe_stall: 1'b0};
    localparam pipe_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                           idex_bubble: 1'b0, pipe_stall: 1'b1};
    localparam pipe_ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                           idex_bubble: 1'b1, pipe_stall: 1'b0};
    localparam pipe_ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                           idex_bubble: 1'b1, pipe_stall: 1'b0};
    localparam pipe_ctrl_t CTRL_FLOW   = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                           idex_bubble: 1'b0, pipe_stall: 1'b0};

    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a == b);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID-stage read of a register that the load
// sitting in ID/EX has not produced yet. Kept standalone for forwarding reuse.
module hazard_detect
    import hazard_pkg::*;
(
    input  logic       i_mem_read,
    input  logic [4:0] i_rd_addr,
    input  logic [4:0] i_rs1_addr,
    input  logic [4:0] i_rs2_addr,
    output logic       o_load_use
);

    logic w_rd_live;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // x0 is hard-wired zero, so a load targeting it can never create a hazard.
    assign w_rd_live  = (i_rd_addr != REG_X0);
    assign w_rs1_hit  = reg_match(i_rd_addr, i_rs1_addr);
    assign w_rs2_hit  = reg_match(i_rd_addr, i_rs2_addr);
    assign o_load_use = i_mem_read & w_rd_live & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: drives PC / IF/ID / ID/EX controls for load-use stalls,
// branch flushes and whole-pipe freezes while data memory is outstanding.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int WAIT_W   = 8,
    parameter int MAX_WAIT = 200
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_RDaddr_i,
    input  logic [4:0]       IFID_RS1addr_i,
    input  logic [4:0]       IFID_RS2addr_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             PC_write_o,
    output logic             IFID_write_o,
    output logic             IFID_flush_o,
    output logic             IDEX_bubble_o,
    output logic             pipe_stall_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [WAIT_W-1:0] WAIT_ZERO  = {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0] WAIT_ONE   = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [WAIT_W-1:0] WAIT_SAT   = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0] TIMEOUT_AT = WAIT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0]  STALL_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            r_state;
    state_e            w_state_next;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_cnt_next;
    logic              r_mem_timeout;
    logic              w_mem_timeout_next;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_load_use;
    logic              w_mem_block;
    logic              w_stall_inc;
    pipe_ctrl_t        w_core_ctrl;
    pipe_ctrl_t        w_out_ctrl;

    hazard_detect u_hazard_detect (
        .i_mem_read (IDEX_MemRead_i),
        .i_rd_addr  (IDEX_RDaddr_i),
        .i_rs1_addr (IFID_RS1addr_i),
        .i_rs2_addr (IFID_RS2addr_i),
        .o_load_use (w_load_use)
    );

    // An ack in the request cycle completes the access without any freeze.
    assign w_mem_block = mem_req_i & ~mem_ack_i;

    // State register with memory-wait counter and sticky timeout flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state       <= RUN;
            r_wait_cnt    <= WAIT_ZERO;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_wait_cnt    <= w_wait_cnt_next;
            r_mem_timeout <= w_mem_timeout_next;
        end
    end

    // Next-state decode; everything holds while the pipe is not enabled.
    always_comb begin
        w_state_next       = r_state;
        w_wait_cnt_next    = r_wait_cnt;
        w_mem_timeout_next = r_mem_timeout;
        if (start_i) begin
            case (r_state)
                RUN: begin
                    if (w_mem_block) begin
                        w_state_next    = MEM_WAIT;
                        w_wait_cnt_next = WAIT_ONE;
                    end else begin
                        w_state_next    = RUN;
                        w_wait_cnt_next = WAIT_ZERO;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack_i) begin
                        w_state_next    = RUN;
                        w_wait_cnt_next = WAIT_ZERO;
                    end else begin
                        w_state_next = MEM_WAIT;
                        if (r_wait_cnt != WAIT_SAT) begin
                            w_wait_cnt_next = r_wait_cnt + WAIT_ONE;
                        end else begin
                            w_wait_cnt_next = r_wait_cnt;
                        end
                        if (r_wait_cnt >= TIMEOUT_AT) begin
                            w_mem_timeout_next = 1'b1;
                        end else begin
                            w_mem_timeout_next = r_mem_timeout;
                        end
                    end
                end
                default: begin
                    w_state_next    = RUN;
                    w_wait_cnt_next = WAIT_ZERO;
                end
            endcase
        end else begin
            w_state_next       = r_state;
            w_wait_cnt_next    = r_wait_cnt;
            w_mem_timeout_next = r_mem_timeout;
        end
    end

    // Output decode: memory freeze outranks branch flush, which outranks load-use.
    always_comb begin
        w_core_ctrl = CTRL_HALT;
        case (r_state)
            RUN: begin
                if (w_mem_block) begin
                    w_core_ctrl = CTRL_FREEZE;
                end else if (branch_taken_i) begin
                    w_core_ctrl = CTRL_FLUSH;
                end else if (w_load_use) begin
                    w_core_ctrl = CTRL_BUBBLE;
                end else begin
                    w_core_ctrl = CTRL_FLOW;
                end
            end
            MEM_WAIT: begin
                w_core_ctrl = CTRL_FREEZE;
            end
            default: begin
                w_core_ctrl = CTRL_HALT;
            end
        endcase
    end

    // Reset and a disabled pipe force the halt pattern without waiting for a clock.
    always_comb begin
        w_out_ctrl = CTRL_HALT;
        if (rst_i && start_i) begin
            w_out_ctrl = w_core_ctrl;
        end else begin
            w_out_ctrl = CTRL_HALT;
        end
    end

    assign w_stall_inc = start_i & ~w_core_ctrl.pc_write;

    // Performance counter of enabled cycles in which the PC did not advance.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end else if (w_stall_inc) begin
            r_stall_cnt <= r_stall_cnt + STALL_ONE;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign PC_write_o    = w_out_ctrl.pc_write;
    assign IFID_write_o  = w_out_ctrl.ifid_write;
    assign IFID_flush_o  = w_out_ctrl.ifid_flush;
    assign IDEX_bubble_o = w_out_ctrl.idex_bubble;
    assign pipe_stall_o  = w_out_ctrl.pipe_stall;
    assign mem_timeout_o = r_mem_timeout;
    assign stall_cnt_o   = r_stall_cnt;

endmodule
